// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and types for the counter command path
package counter_pkg;

  localparam int CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, debounce counter and registered rise pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_meta;
  logic          sync_q;
  logic          level_q;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      rise       <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      level_q   <= level;
      rise      <= level & ~level_q;
      // Any sample agreeing with the current level restarts the run of disagreeing samples.
      if (sync_q != level) begin
        if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          level      <= sync_q;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_ctrl.sv
// rtl/counter_cmd_ctrl.sv - button arbitration and pulse generation for the up/down counter
// Hold-to-repeat is compiled in when COUNTER_CMD_AUTOREPEAT_EN is defined.
module counter_cmd_ctrl
  import counter_pkg::*;
#(
  parameter int               CNT_W           = CNT_W_DEFAULT,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [CNT_W-1:0] RESET_LIMIT     = CNT_W'(4'hF),
  parameter int               REPEAT_DELAY    = 16,
  parameter int               REPEAT_PERIOD   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_load,
  input  logic [CNT_W-1:0] sw_limit,
  output logic             count_inc,
  output logic             count_dec,
  output logic             load_en,
  output logic [CNT_W-1:0] count_to
);

  logic up_lvl, up_rise, down_lvl, down_rise, load_lvl, load_rise;
  logic acc_inc, acc_dec, acc_load;
  logic rep_inc, rep_dec;
  logic unused_cfg;
  logic [CNT_W-1:0] sw_meta, sw_sync;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset_n(reset_n), .btn(btn_up), .level(up_lvl), .rise(up_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .reset_n(reset_n), .btn(btn_down), .level(down_lvl), .rise(down_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .reset_n(reset_n), .btn(btn_load), .level(load_lvl), .rise(load_rise)
  );

  // Load wins outright; simultaneous inc and dec cancel each other.
  assign acc_load = load_rise;
  assign acc_inc  = up_rise & ~down_rise & ~load_rise;
  assign acc_dec  = down_rise & ~up_rise & ~load_rise;

`ifdef COUNTER_CMD_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = $clog2(REPEAT_PERIOD + 1);

  rpt_state_t    state_q, state_d;
  logic          dir_q;
  logic          held_lvl;
  logic          any_acc;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;

  assign any_acc    = acc_load | acc_inc | acc_dec;
  assign held_lvl   = (dir_q == DIR_UP) ? up_lvl : down_lvl;
  assign unused_cfg = load_lvl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (acc_inc)      dir_q <= DIR_UP;
      else if (acc_dec) dir_q <= DIR_DOWN;
      if (state_d != state_q) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else if (state_q == HELD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else if (state_q == REPEAT) begin
        rep_cnt <= (rep_cnt == RW'(REPEAT_PERIOD - 1)) ? '0 : rep_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc_inc || acc_dec) state_d = HELD;
      HELD: begin
        if (any_acc || !held_lvl)                       state_d = IDLE;
        else if (hold_cnt == HW'(REPEAT_DELAY - 1))     state_d = REPEAT;
      end
      REPEAT:  if (any_acc || !held_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entering REPEAT issues the first repeat; later ones follow every REPEAT_PERIOD cycles.
  always_comb begin
    rep_inc = 1'b0;
    rep_dec = 1'b0;
    if ((state_q == HELD && state_d == REPEAT) ||
        (state_q == REPEAT && state_d == REPEAT && rep_cnt == RW'(REPEAT_PERIOD - 1))) begin
      rep_inc = (dir_q == DIR_UP);
      rep_dec = (dir_q == DIR_DOWN);
    end
  end
`else
  assign rep_inc    = 1'b0;
  assign rep_dec    = 1'b0;
  assign unused_cfg = ^{load_lvl, up_lvl, down_lvl, REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      count_inc <= 1'b0;
      count_dec <= 1'b0;
      load_en   <= 1'b0;
      count_to  <= RESET_LIMIT;
    end else begin
      sw_meta   <= sw_limit;
      sw_sync   <= sw_meta;
      count_inc <= acc_inc | rep_inc;
      count_dec <= acc_dec | rep_dec;
      load_en   <= acc_load;
      if (acc_load) count_to <= sw_sync;
    end
  end

endmodule

// File: doc/counter_cmd_ctrl.md
# counter_cmd_ctrl

Upstream command stage for the 4-bit up/down `Counter`. It turns three raw, asynchronous push-button inputs (up, down, load) and a limit switch bank into the clean single-cycle `count_inc`, `count_dec` and `load_en` pulses and the stable `count_to` value the counter consumes. The block synchronizes, debounces, edge-detects and arbitrates the buttons; optional hold-to-repeat is compiled in by macro.

## Interface
- `CNT_W`, 4, width of `sw_limit` and `count_to`
- `DEBOUNCE_CYCLES`, 4, consecutive stable samples required before a debounced level changes (≥1)
- `RESET_LIMIT`, 4'hF, reset value of `count_to`
- `REPEAT_DELAY`, 16, cycles a button is held before auto-repeat starts (macro only)
- `REPEAT_PERIOD`, 4, cycles between repeat pulses (macro only, ≥2)

Ports:
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `btn_up` in 1: raw async increment button, high = pressed
- `btn_down` in 1: raw async decrement button
- `btn_load` in 1: raw async load button
- `sw_limit` in CNT_W: quasi-static limit switches, sampled only on an accepted load
- `count_inc` out 1: one-cycle increment pulse, registered
- `count_dec` out 1: one-cycle decrement pulse, registered
- `load_en` out 1: one-cycle load pulse, registered
- `count_to` out CNT_W: registered limit value presented to the counter

## Operation
- Each button passes through a 2-FF synchronizer, then a debounce counter. The debounced level flips only after `DEBOUNCE_CYCLES` consecutive synchronized samples that differ from it; any matching sample clears the counter.
- A 0→1 transition of a debounced level raises a one-cycle request.
- Arbitration, same cycle: load > inc/dec.
  - inc and dec requested together with no load: both are dropped and nothing is issued.
  - Losing requests are discarded, never queued.
- Outputs are mutually exclusive; at most one of `count_inc`, `count_dec`, `load_en` is high in any cycle.
- Accepted load: `count_to` is loaded from the synchronized `sw_limit` on the same edge that asserts `load_en`, so both are valid together for the counter's next edge. `count_to` holds otherwise.
- Releases (1→0) produce no output.
- FSM (only active with the macro, otherwise stays in IDLE):
  - IDLE → HELD on an accepted inc or dec; the FSM records the direction and clears the hold counter.
  - HELD → REPEAT when the hold counter reaches `REPEAT_DELAY`.
  - In REPEAT, one pulse of the recorded direction is issued every `REPEAT_PERIOD` cycles.
  - HELD/REPEAT → IDLE on release of the recorded button, or on any new accepted request. The new request is issued normally.

## Timing
- Reset values: all pulses 0, `count_to` = `RESET_LIMIT`, synchronizers/debounced levels 0, FSM IDLE, counters 0.
- Latency: with a raw button rising before edge 0 and held clean, the output pulse is high for exactly one cycle, starting after edge `DEBOUNCE_CYCLES`+3 (edge 7 at default).
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized samples produce no pulse.
- Minimum spacing between two pulses from separate presses is 2·`DEBOUNCE_CYCLES` cycles.
- Reset asserted mid-operation clears everything immediately. A button still held at reset release is treated as a new press and pulses after the normal latency.

## Configuration
- `COUNTER_CMD_AUTOREPEAT_EN` defined: the HELD/REPEAT FSM and the repeat counters are compiled in. The repeat parameters are honoured.
- Not defined: the repeat logic is absent. Exactly one pulse is issued per press regardless of hold time, and the repeat parameters are ignored.
- Load never auto-repeats in either build.

## Structure
- Shared package `counter_pkg`: `CNT_W` default, FSM state typedef (IDLE, HELD, REPEAT), direction encoding constants.
- Sub-module `btn_debounce`: synchronizer, debounce counter and rise-edge output. It is instantiated three times. Arbitration, the FSM and output registers live in the top.

## Test plan
- Reset, then a clean `btn_up` press held 20 cycles → one `count_inc` pulse after edge 7, `count_to`=4'hF throughout.
- `sw_limit`=4'h5, press `btn_load` → `load_en` one cycle with `count_to`=4'h5 on the same cycle; `count_to` stays 5 after `sw_limit` changes.
- 2-cycle glitch on `btn_down`, then a bouncy press (3 toggles, then stable) → no pulse from the glitch, exactly one `count_dec` from the press.
- `btn_up` and `btn_down` rising in the same cycle → no pulse. `btn_load` and `btn_up` together → only `load_en`.
- Macro defined, `btn_up` held 40 cycles → first pulse at edge 7, next at edge 7+16, then every 4 cycles until release; no pulse after release.
- `reset_n` low for 3 cycles while `btn_down` is held → outputs 0 at once; one `count_dec` 7 edges after release of reset.
